// File: rtl/spi_sram_responder.sv
// SPI mode-0 SRAM target (READ 0x03 / WRITE 0x02) backed by on-chip byte memory, all logic on clk.
// miso follows an spi_clk fall within 3 clk; the initiator paces everything, so there is no backpressure.
module spi_sram_responder #(
  parameter int    ADDR_BITS = 10,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_clk,
  input  logic                 spi_mosi,
  input  logic                 spi_select,
  output logic                 spi_miso,
  output logic                 dbg_wr,
  output logic [ADDR_BITS-1:0] dbg_addr,
  output logic [7:0]           dbg_data
);

  // The shifter only needs to hold what is still inspected: the command/data byte or the low address bits.
  localparam int SR_W = (ADDR_BITS - 1 > 7) ? ADDR_BITS - 1 : 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    READ   = 3'd3,
    WRITE  = 3'd4,
    IGNORE = 3'd5
  } state_t;

  state_t state, state_next;

  logic [2:0] sclk_sync;
  logic [2:0] sel_sync;
  logic [1:0] mosi_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync <= '0;
      sel_sync  <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_clk};
      sel_sync  <= {sel_sync[1:0], spi_select};
      mosi_sync <= {mosi_sync[0], spi_mosi};
    end
  end

  logic sclk_rise, sclk_fall, sel_fall, desel, mosi_bit;
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign sel_fall  = ~sel_sync[1] & sel_sync[2];
  assign desel     = sel_sync[1] & ~sel_sync[2];
  assign mosi_bit  = mosi_sync[1];

  logic [SR_W-1:0]      sr;
  logic [4:0]           bit_cnt;
  logic                 is_write;
  logic [ADDR_BITS-1:0] ptr;
  logic [7:0]           tx;
  logic [2:0]           rd_cnt;
  logic                 out_en;
  logic [1:0]           load_pipe;
  logic [7:0]           rd_data;
  logic [7:0]           rx_byte;
  logic [ADDR_BITS-1:0] addr_low;

  assign rx_byte  = {sr[6:0], mosi_bit};
  assign addr_low = {sr[ADDR_BITS-2:0], mosi_bit};

  logic start, shift_in, cmd_done, addr_done, wr_commit;
  logic tx_first, tx_shift, tx_next_byte, tx_load;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    start        = 1'b0;
    shift_in     = 1'b0;
    cmd_done     = 1'b0;
    addr_done    = 1'b0;
    wr_commit    = 1'b0;
    tx_first     = 1'b0;
    tx_shift     = 1'b0;
    tx_next_byte = 1'b0;
    if (desel) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (sel_fall) begin
            state_next = CMD;
            start      = 1'b1;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            shift_in = 1'b1;
            if (bit_cnt == 5'd7) begin
              cmd_done = 1'b1;
              if (rx_byte == 8'h03 || rx_byte == 8'h02) state_next = ADDR;
              else                                      state_next = IGNORE;
            end
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            shift_in = 1'b1;
            if (bit_cnt == 5'd23) begin
              addr_done  = 1'b1;
              state_next = is_write ? WRITE : READ;
            end
          end
        end
        READ: begin
          if (sclk_fall) begin
            if (!out_en)              tx_first     = 1'b1;
            else if (rd_cnt == 3'd7)  tx_next_byte = 1'b1;
            else                      tx_shift     = 1'b1;
          end
        end
        WRITE: begin
          if (sclk_rise) begin
            shift_in = 1'b1;
            if (bit_cnt == 5'd7) wr_commit = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // load_pipe[1] lands two clk after the address completes: one for ptr, one for the RAM read.
  assign tx_load = load_pipe[1] | tx_next_byte;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr        <= '0;
      bit_cnt   <= '0;
      is_write  <= 1'b0;
      ptr       <= '0;
      tx        <= '0;
      rd_cnt    <= '0;
      out_en    <= 1'b0;
      load_pipe <= '0;
      dbg_wr    <= 1'b0;
      dbg_addr  <= '0;
      dbg_data  <= '0;
    end else begin
      dbg_wr <= wr_commit;
      if (wr_commit) begin
        dbg_addr <= ptr;
        dbg_data <= rx_byte;
      end
      if (desel) begin
        bit_cnt   <= '0;
        out_en    <= 1'b0;
        load_pipe <= '0;
      end else begin
        if (start) begin
          bit_cnt <= '0;
          out_en  <= 1'b0;
        end else if (shift_in) begin
          sr      <= {sr[SR_W-2:0], mosi_bit};
          bit_cnt <= (cmd_done || addr_done || wr_commit) ? 5'd0 : bit_cnt + 5'd1;
        end
        if (cmd_done) is_write <= ~mosi_bit;
        load_pipe <= {load_pipe[0], addr_done & ~is_write};
        if (addr_done)                 ptr <= addr_low;
        else if (wr_commit || tx_load) ptr <= ptr + ADDR_BITS'(1);
        if (tx_load) begin
          tx     <= rd_data;
          rd_cnt <= '0;
        end else if (tx_shift) begin
          tx     <= {tx[6:0], 1'b0};
          rd_cnt <= rd_cnt + 3'd1;
        end
        if (tx_first) out_en <= 1'b1;
      end
    end
  end

  assign spi_miso = (state == READ) & out_en & tx[7];

  logic [7:0] mem [2**ADDR_BITS];

  // Read port runs every cycle on ptr; a write port shares the same address.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[ptr] <= rx_byte;
    rd_data <= mem[ptr];
  end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: SPI initiator tasks with spi_clk = clk/10 and hand-computed expectations.
module tb_spi_sram_responder;

  localparam int HALF = 5;

  logic       clk;
  logic       rstn;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_select;
  logic       spi_miso;
  logic       dbg_wr;
  logic [9:0] dbg_addr;
  logic [7:0] dbg_data;

  spi_sram_responder dut (
    .clk        (clk),
    .rstn       (rstn),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_select (spi_select),
    .spi_miso   (spi_miso),
    .dbg_wr     (dbg_wr),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] wa [$];
  logic [7:0] wd [$];
  always @(negedge clk) begin
    if (dbg_wr) begin
      wa.push_back(dbg_addr);
      wd.push_back(dbg_data);
    end
  end

  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sel_low();
    spi_select = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic sel_high();
    wait_clk(HALF);
    spi_select = 1'b1;
    wait_clk(8);
  endtask

  task automatic xfer(input logic [7:0] dout, input int nbits, output logic [7:0] din);
    din = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = dout[7-i];
      wait_clk(HALF);
      din = {din[6:0], spi_miso};
      spi_clk = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] d;
    xfer(cmd, 8, d);
    xfer(a[23:16], 8, d);
    xfer(a[15:8], 8, d);
    xfer(a[7:0], 8, d);
  endtask

  initial begin
    logic [7:0] rx;
    int base;

    rstn = 1'b0; spi_clk = 1'b0; spi_mosi = 1'b0; spi_select = 1'b1;
    wait_clk(3);
    check("reset_miso", 32'(spi_miso), 32'h0);
    check("reset_dbg_wr", 32'(dbg_wr), 32'h0);
    check("reset_dbg_addr", 32'(dbg_addr), 32'h0);
    check("reset_dbg_data", 32'(dbg_data), 32'h0);
    rstn = 1'b1;
    wait_clk(4);

    // write A5 3C at 0x010
    base = wa.size();
    sel_low(); hdr(8'h02, 24'h000010);
    xfer(8'hA5, 8, rx); xfer(8'h3C, 8, rx);
    sel_high();
    check("wr1_count", 32'(wa.size() - base), 32'd2);
    check("wr1_addr0", 32'(wa[base]), 32'h010);
    check("wr1_data0", 32'(wd[base]), 32'hA5);
    check("wr1_addr1", 32'(wa[base+1]), 32'h011);
    check("wr1_data1", 32'(wd[base+1]), 32'h3C);

    sel_low(); hdr(8'h03, 24'h000010);
    xfer(8'h00, 8, rx); check("rd1_byte0", 32'(rx), 32'hA5);
    xfer(8'h00, 8, rx); check("rd1_byte1", 32'(rx), 32'h3C);
    sel_high();

    // wrap-around at the top of a 1 KiB memory
    base = wa.size();
    sel_low(); hdr(8'h02, 24'h0003FF);
    xfer(8'h11, 8, rx); xfer(8'h22, 8, rx);
    sel_high();
    check("wrap_count", 32'(wa.size() - base), 32'd2);
    check("wrap_addr0", 32'(wa[base]), 32'h3FF);
    check("wrap_data0", 32'(wd[base]), 32'h11);
    check("wrap_addr1", 32'(wa[base+1]), 32'h000);
    check("wrap_data1", 32'(wd[base+1]), 32'h22);

    sel_low(); hdr(8'h03, 24'h0003FF);
    xfer(8'h00, 8, rx); check("wrap_rd0", 32'(rx), 32'h11);
    xfer(8'h00, 8, rx); check("wrap_rd1", 32'(rx), 32'h22);
    sel_high();

    sel_low(); hdr(8'h03, 24'hFFFC00);
    xfer(8'h00, 8, rx); check("alias_rd", 32'(rx), 32'h22);
    sel_high();

    // partial byte: 0x021 is preset, then a 12-bit write at 0x020 must only commit 0x020
    base = wa.size();
    sel_low(); hdr(8'h02, 24'h000021);
    xfer(8'h5A, 8, rx);
    sel_high();
    check("preset_count", 32'(wa.size() - base), 32'd1);

    base = wa.size();
    sel_low(); hdr(8'h02, 24'h000020);
    xfer(8'h77, 8, rx); xfer(8'hF0, 4, rx);
    spi_mosi = 1'b0;
    sel_high();
    check("partial_count", 32'(wa.size() - base), 32'd1);
    check("partial_addr", 32'(wa[base]), 32'h020);
    check("partial_data", 32'(wd[base]), 32'h77);

    sel_low(); hdr(8'h03, 24'h000021);
    xfer(8'h00, 8, rx); check("partial_untouched", 32'(rx), 32'h5A);
    sel_high();

    // unknown command: miso stays low, nothing committed
    base = wa.size();
    sel_low();
    xfer(8'h9F, 8, rx);
    for (int i = 0; i < 4; i++) begin
      xfer(8'hFF, 8, rx);
      check("unknown_miso", 32'(rx), 32'h00);
    end
    spi_mosi = 1'b0;
    sel_high();
    check("unknown_dbg_count", 32'(wa.size() - base), 32'd0);

    sel_low(); hdr(8'h03, 24'h000010);
    xfer(8'h00, 8, rx); check("after_unknown_rd", 32'(rx), 32'hA5);
    sel_high();

    // reset in the middle of a read
    sel_low(); hdr(8'h03, 24'h000010);
    spi_mosi = 1'b0;
    wait_clk(HALF);
    check("midread_miso_before", 32'(spi_miso), 32'h1);
    rstn = 1'b0;
    #1;
    check("midread_miso_reset", 32'(spi_miso), 32'h0);
    check("midread_dbg_wr_reset", 32'(dbg_wr), 32'h0);
    wait_clk(3);
    rstn = 1'b1;
    spi_select = 1'b1;
    wait_clk(8);

    sel_low(); hdr(8'h03, 24'h000011);
    xfer(8'h00, 8, rx); check("after_reset_rd", 32'(rx), 32'h3C);
    sel_high();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
